// File: rtl/code_entry.sv
// code_entry: keypad digit collector feeding the 4-digit BCD code comparator.
// Collects up to four decimal keys, issues a one-cycle submit pulse on enter,
// and handles clear, short-entry rejection and inactivity timeout.
// Optional build macro: CODE_ENTRY_BACKSPACE_EN (key 4'hC acts as backspace).
module code_entry #(
  parameter int unsigned      CNT_W          = 26,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic [3:0] bcd_0_o,
  output logic [3:0] bcd_1_o,
  output logic [3:0] bcd_2_o,
  output logic [3:0] bcd_3_o,
  output logic       enable_o,
  output logic [2:0] count_o,
  output logic       reject_o,
  output logic       timeout_o
);

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
`ifdef CODE_ENTRY_BACKSPACE_EN
  localparam logic [3:0] KEY_BKSP      = 4'hC;
`endif
  localparam logic [2:0]       CNT_FULL = 3'd4;
  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_SUBMIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       bcd0_q, bcd0_d;
  logic [3:0]       bcd1_q, bcd1_d;
  logic [3:0]       bcd2_q, bcd2_d;
  logic [3:0]       bcd3_q, bcd3_d;
  logic [2:0]       count_q, count_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             enable_q, enable_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;

  logic key_digit_c;
  logic key_clear_c;
  logic key_enter_c;
`ifdef CODE_ENTRY_BACKSPACE_EN
  logic key_bksp_c;
`endif
  logic tmo_hit_c;

  // Key classification; codes outside these classes are ignored entirely
  always_comb begin
    key_digit_c = key_valid_i && (key_code_i <= KEY_MAX_DIGIT);
    key_clear_c = key_valid_i && (key_code_i == KEY_CLEAR);
    key_enter_c = key_valid_i && (key_code_i == KEY_ENTER);
`ifdef CODE_ENTRY_BACKSPACE_EN
    key_bksp_c  = key_valid_i && (key_code_i == KEY_BKSP);
`endif
    tmo_hit_c   = (timer_q == TMO_LAST);
  end

  // Next-state, datapath and pulse decode
  always_comb begin
    logic wipe;
    state_d   = state_q;
    bcd0_d    = bcd0_q;
    bcd1_d    = bcd1_q;
    bcd2_d    = bcd2_q;
    bcd3_d    = bcd3_q;
    count_d   = count_q;
    timer_d   = timer_q;
    enable_d  = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    wipe      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        // Timer only runs while a partial code is held
        timer_d = (state_q == ST_ENTRY) ? timer_q + CNT_W'(1) : '0;
        if (key_digit_c) begin
          bcd3_d  = bcd2_q;
          bcd2_d  = bcd1_q;
          bcd1_d  = bcd0_q;
          bcd0_d  = key_code_i;
          count_d = count_q + 3'd1;
          state_d = (count_q == CNT_FULL - 3'd1) ? ST_FULL : ST_ENTRY;
          timer_d = '0;
        end else if (key_enter_c) begin
          reject_d = 1'b1;
          timer_d  = '0;
        end else if (key_clear_c) begin
          wipe = 1'b1;
`ifdef CODE_ENTRY_BACKSPACE_EN
        end else if (key_bksp_c && (state_q == ST_ENTRY)) begin
          bcd0_d  = bcd1_q;
          bcd1_d  = bcd2_q;
          bcd2_d  = bcd3_q;
          bcd3_d  = 4'd0;
          count_d = count_q - 3'd1;
          state_d = (count_q == 3'd1) ? ST_IDLE : ST_ENTRY;
          timer_d = '0;
`endif
        end else if ((state_q == ST_ENTRY) && tmo_hit_c) begin
          wipe      = 1'b1;
          timeout_d = 1'b1;
        end
      end

      ST_FULL: begin
        timer_d = timer_q + CNT_W'(1);
        if (key_digit_c) begin
          // Extra digits are dropped but still count as activity
          timer_d = '0;
        end else if (key_enter_c) begin
          state_d  = ST_SUBMIT;
          enable_d = 1'b1;
          timer_d  = '0;
        end else if (key_clear_c) begin
          wipe = 1'b1;
`ifdef CODE_ENTRY_BACKSPACE_EN
        end else if (key_bksp_c) begin
          bcd0_d  = bcd1_q;
          bcd1_d  = bcd2_q;
          bcd2_d  = bcd3_q;
          bcd3_d  = 4'd0;
          count_d = count_q - 3'd1;
          state_d = ST_ENTRY;
          timer_d = '0;
`endif
        end else if (tmo_hit_c) begin
          wipe      = 1'b1;
          timeout_d = 1'b1;
        end
      end

      ST_SUBMIT: begin
        // Digits were held for the comparator this cycle; drop them unconditionally
        wipe = 1'b1;
      end

      default: begin
        wipe = 1'b1;
      end
    endcase

    if (wipe) begin
      state_d = ST_IDLE;
      bcd0_d  = 4'd0;
      bcd1_d  = 4'd0;
      bcd2_d  = 4'd0;
      bcd3_d  = 4'd0;
      count_d = 3'd0;
      timer_d = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bcd0_q    <= 4'd0;
      bcd1_q    <= 4'd0;
      bcd2_q    <= 4'd0;
      bcd3_q    <= 4'd0;
      count_q   <= 3'd0;
      timer_q   <= '0;
      enable_q  <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd0_q    <= bcd0_d;
      bcd1_q    <= bcd1_d;
      bcd2_q    <= bcd2_d;
      bcd3_q    <= bcd3_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      enable_q  <= enable_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  assign bcd_0_o   = bcd0_q;
  assign bcd_1_o   = bcd1_q;
  assign bcd_2_o   = bcd2_q;
  assign bcd_3_o   = bcd3_q;
  assign count_o   = count_q;
  assign enable_o  = enable_q;
  assign reject_o  = reject_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed vector table, timeout
// sequences, and random keys checked against a queue-based reference model.
module tb_code_entry;

  localparam int unsigned CNT_W = 26;
  localparam int TMO = 8;
`ifdef CODE_ENTRY_BACKSPACE_EN
  localparam bit BK = 1'b1;
`else
  localparam bit BK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kv  = 1'b0;
  logic [3:0] kc  = 4'd0;
  logic [3:0] b0, b1, b2, b3;
  logic       en_o, rej_o, to_o;
  logic [2:0] cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  code_entry #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(26'd8)) dut (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_code_i(kc),
    .bcd_0_o(b0), .bcd_1_o(b1), .bcd_2_o(b2), .bcd_3_o(b3),
    .enable_o(en_o), .count_o(cnt_o), .reject_o(rej_o), .timeout_o(to_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [3:0]  k;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        en;
    logic        rej;
    logic        to;
  } vec_t;

  vec_t vq[$];

  // Reference model: held digits as a queue (oldest first)
  logic [3:0] mq[$];
  bit         m_sub;
  int         m_idle;
  logic       m_en, m_rej, m_to;

  task automatic add(input logic r, input logic v, input logic [3:0] k,
                     input logic [15:0] bcd, input logic [2:0] cnt,
                     input logic en, input logic rej, input logic to);
    vec_t t;
    t.r = r; t.v = v; t.k = k; t.bcd = bcd; t.cnt = cnt;
    t.en = en; t.rej = rej; t.to = to;
    vq.push_back(t);
  endtask

  // One clock: drive at negedge, outputs settle #1 after posedge
  task automatic cycle(input logic r, input logic v, input logic [3:0] k);
    @(negedge clk);
    rst = r; kv = v; kc = k;
    @(posedge clk);
    #1;
    rst = 1'b0; kv = 1'b0; kc = 4'd0;
  endtask

  task automatic check(input string name, input logic [15:0] eb, input logic [2:0] ec,
                       input logic een, input logic erej, input logic eto);
    logic [22:0] act, exp;
    act = {b3, b2, b1, b0, cnt_o, en_o, rej_o, to_o};
    exp = {eb, ec, een, erej, eto};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got bcd3..0=%h count=%0d en=%b rej=%b to=%b, expected bcd3..0=%h count=%0d en=%b rej=%b to=%b",
               name, $time, {b3, b2, b1, b0}, cnt_o, en_o, rej_o, to_o, eb, ec, een, erej, eto);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] k);
    bit acc;
    m_en = 1'b0; m_rej = 1'b0; m_to = 1'b0;
    if (r) begin
      mq.delete(); m_sub = 0; m_idle = 0;
    end else if (m_sub) begin
      mq.delete(); m_sub = 0; m_idle = 0;
    end else begin
      acc = v && (k <= 4'd9 || k == 4'hA || k == 4'hB || (BK && k == 4'hC && mq.size() > 0));
      if (acc) begin
        m_idle = 0;
        if (k <= 4'd9) begin
          if (mq.size() < 4) mq.push_back(k);
        end else if (k == 4'hA) begin
          mq.delete();
        end else if (k == 4'hB) begin
          if (mq.size() == 4) begin m_sub = 1; m_en = 1'b1; end
          else m_rej = 1'b1;
        end else begin
          void'(mq.pop_back());
        end
      end else if (mq.size() > 0) begin
        if (m_idle == TMO - 1) begin
          mq.delete(); m_idle = 0; m_to = 1'b1;
        end else begin
          m_idle++;
        end
      end
    end
  endtask

  function automatic logic [15:0] model_bcd();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i < mq.size()) r[i*4 +: 4] = mq[mq.size() - 1 - i];
    return r;
  endfunction

  initial begin
    // Directed table: one row per clock
    add(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0);  // reset
    add(0, 1, 4'h1, 16'h0001, 1, 0, 0, 0);
    add(0, 1, 4'h0, 16'h0010, 2, 0, 0, 0);
    add(0, 1, 4'h8, 16'h0108, 3, 0, 0, 0);
    add(0, 1, 4'h2, 16'h1082, 4, 0, 0, 0);
    add(0, 1, 4'hB, 16'h1082, 4, 1, 0, 0);  // submit
    add(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'h5, 16'h0005, 1, 0, 0, 0);
    add(0, 1, 4'h7, 16'h0057, 2, 0, 0, 0);
    add(0, 1, 4'hB, 16'h0057, 2, 0, 1, 0);  // short entry
    add(0, 0, 4'h0, 16'h0057, 2, 0, 0, 0);
    add(0, 1, 4'hA, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'h1, 16'h0001, 1, 0, 0, 0);
    add(0, 1, 4'h0, 16'h0010, 2, 0, 0, 0);
    add(0, 1, 4'h8, 16'h0108, 3, 0, 0, 0);
    add(0, 1, 4'h2, 16'h1082, 4, 0, 0, 0);
    add(0, 1, 4'h9, 16'h1082, 4, 0, 0, 0);  // fifth digit dropped
    add(0, 1, 4'hA, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'hD, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'h4, 16'h0004, 1, 0, 0, 0);
    add(0, 1, 4'h6, 16'h0046, 2, 0, 0, 0);
    if (BK) add(0, 1, 4'hC, 16'h0004, 1, 0, 0, 0);
    else    add(0, 1, 4'hC, 16'h0046, 2, 0, 0, 0);
    add(0, 1, 4'hA, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'hC, 16'h0000, 0, 0, 0, 0);  // C in idle
    add(0, 1, 4'h3, 16'h0003, 1, 0, 0, 0);
    add(0, 1, 4'h4, 16'h0034, 2, 0, 0, 0);
    add(0, 1, 4'h1, 16'h0341, 3, 0, 0, 0);
    add(1, 1, 4'h5, 16'h0000, 0, 0, 0, 0);  // reset with count 3, key ignored
    add(0, 1, 4'hB, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'h1, 16'h0001, 1, 0, 0, 0);
    add(0, 1, 4'h2, 16'h0012, 2, 0, 0, 0);
    add(0, 1, 4'h3, 16'h0123, 3, 0, 0, 0);
    add(0, 1, 4'h4, 16'h1234, 4, 0, 0, 0);
    add(0, 1, 4'hB, 16'h1234, 4, 1, 0, 0);
    add(1, 1, 4'hB, 16'h0000, 0, 0, 0, 0);  // reset during submit
    add(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].r, vq[i].v, vq[i].k);
      check($sformatf("vec%0d", i), vq[i].bcd, vq[i].cnt, vq[i].en, vq[i].rej, vq[i].to);
    end

    // Timeout: fires on the 8th idle edge after the last key
    cycle(1, 0, 4'h0);
    cycle(0, 1, 4'h3);
    check("tmo_key", 16'h0003, 1, 0, 0, 0);
    for (int i = 1; i < TMO; i++) begin
      cycle(0, 0, 4'h0);
      check($sformatf("tmo_wait%0d", i), 16'h0003, 1, 0, 0, 0);
    end
    cycle(0, 0, 4'h0);
    check("tmo_fire", 16'h0000, 0, 0, 0, 1);
    cycle(0, 0, 4'h0);
    check("tmo_after", 16'h0000, 0, 0, 0, 0);

    // Key on the expiring cycle wins over the timeout
    cycle(0, 1, 4'h3);
    for (int i = 1; i < TMO; i++) cycle(0, 0, 4'h0);
    cycle(0, 1, 4'h5);
    check("tmo_race", 16'h0035, 2, 0, 0, 0);
    for (int i = 1; i < TMO; i++) cycle(0, 0, 4'h0);
    check("tmo_race_wait", 16'h0035, 2, 0, 0, 0);
    cycle(0, 0, 4'h0);
    check("tmo_race_fire", 16'h0000, 0, 0, 0, 1);

    // Randomized keys against the reference model
    cycle(1, 0, 4'h0);
    model_step(1, 0, 4'h0);
    check("rnd_reset", model_bcd(), 3'(mq.size()), m_en, m_rej, m_to);
    for (int i = 0; i < 4000; i++) begin
      logic r, v;
      logic [3:0] k;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 99) < 35);
      k = 4'($urandom_range(0, 15));
      cycle(r, v, k);
      model_step(r, v, k);
      check($sformatf("rnd%0d", i), model_bcd(), 3'(mq.size()), m_en, m_rej, m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry.md
Name: code_entry

Overview:
- Keypad digit-collection stage that sits directly upstream of the 4-digit BCD code comparator.
- Accumulates up to four decimal key presses into a shift register and presents them as four BCD digits.
- Issues a one-cycle enable pulse on the enter key, so the comparator's equal output is a single-cycle qualified pulse.
- Handles clear, incomplete-entry rejection and inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 26'd50_000_000: inactivity limit in clk_i cycles (1 s at 50 MHz); must be ≥ 2.
- CNT_W, 26: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- key_valid_i  input  1  single-cycle strobe: key_code_i is valid this cycle.
- key_code_i  input  4  key code: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored.
- bcd_0_o  output  4  most recently entered digit; feeds comparator bcd_0_i.
- bcd_1_o  output  4  second most recent digit.
- bcd_2_o  output  4  third most recent digit.
- bcd_3_o  output  4  first-entered digit of a full code.
- enable_o  output  1  one-cycle submit pulse; feeds comparator enable_i.
- count_o  output  3  number of digits held, 0-4.
- reject_o  output  1  one-cycle pulse: enter pressed with fewer than 4 digits.
- timeout_o  output  1  one-cycle pulse: entry abandoned due to inactivity.

Behaviour:
- All outputs are registered. A key sampled at edge n is reflected on outputs immediately after edge n.
- Reset (rst_i=1 at an edge, in any state): state=IDLE; all bcd_*_o=0; count_o=0; enable_o, reject_o, timeout_o=0; timer=0. Reset has priority over all other inputs.
- States:
  - IDLE: count 0.
  - ENTRY: count 1-3.
  - FULL: count 4.
  - SUBMIT: one cycle, enable_o=1.
- Digit key in IDLE/ENTRY: shift bcd_3←bcd_2←bcd_1←bcd_0←key; count++; go to FULL when count reaches 4, else ENTRY.
- Digit key in FULL: ignored; digits unchanged; timer is still restarted.
- Typing 1,0,8,2 yields bcd_3..bcd_0 = 1,0,8,2.
- Enter in FULL:
  - go to SUBMIT; enable_o=1 for exactly one cycle with digits held stable.
  - next edge → IDLE; digits cleared to 0; count_o=0.
- Enter in IDLE/ENTRY: reject_o=1 for one cycle; state and digits unchanged.
- Clear in IDLE/ENTRY/FULL: → IDLE; digits 0; count 0. No pulse output.
- Any key during SUBMIT: ignored; the SUBMIT → IDLE transition is unconditional.
- Codes 4'hC-4'hF: ignored entirely, including no timer restart.
- key_valid_i held high for k cycles counts as k presses; debouncing is done upstream.
- Timer:
  - held at 0 in IDLE and SUBMIT.
  - cleared on every accepted key (digit, enter, clear).
  - otherwise increments in ENTRY/FULL.
  - On the cycle timer == TIMEOUT_CYCLES-1 with no key accepted: → IDLE; digits 0; count 0; timeout_o=1 for one cycle.
  - A key accepted on that same cycle wins: the key is processed, the timer is cleared and no timeout occurs.
- enable_o, reject_o and timeout_o are mutually exclusive and never high on consecutive cycles from the same event.

Optional Feature:
- Macro: CODE_ENTRY_BACKSPACE_EN.
- Defined: 4'hC is backspace.
  - In ENTRY/FULL: shift bcd_0←bcd_1←bcd_2←bcd_3, then bcd_3←0; count--; FULL→ENTRY; count 1→IDLE; timer cleared.
  - In IDLE and SUBMIT: ignored.
- Undefined: 4'hC is ignored like 4'hD-4'hF, and no backspace logic is synthesised.

Test Plan:
- Reset, then keys 1,0,8,2,enter → count_o 1,2,3,4; bcd_3..0 = 1,0,8,2; enable_o high exactly 1 cycle; next cycle all digits 0, count_o=0.
- Keys 5,7,enter → reject_o 1-cycle pulse; count_o stays 2; bcd_1=5, bcd_0=7; no enable_o.
- Keys 1,0,8,2,9 → fifth digit ignored; digits remain 1,0,8,2; then clear → all 0, count_o=0, no pulses.
- TIMEOUT_CYCLES=8: key 3, then idle → timeout_o pulses 8 cycles after the key; count_o→0.
  - Repeat with a digit key on exactly the 8th cycle → no timeout; count_o=2.
- rst_i asserted during SUBMIT or with count 3 → next cycle all outputs 0, state IDLE.
  - Key arriving with rst_i=1 → ignored.
- With CODE_ENTRY_BACKSPACE_EN: keys 4,6,backspace → count_o=1, bcd_0=4, bcd_1=0; backspace in IDLE → no change.
  - Without the macro: key C → no change.
